// File: rtl/ulpi_arb_pkg.sv
// ulpi_arb_pkg: shared types and sizes for the ULPI register arbiter
package ulpi_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;
  localparam int N_REQ = 2;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
endpackage

// File: rtl/ulpi_arb_rr.sv
// ulpi_arb_rr: two-way round-robin pick, the requester other than LAST wins a tie
module ulpi_arb_rr
  import ulpi_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             gnt
);
  assign gnt = &req ? (last != 2'd1) : req[1];
endmodule

// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter: shares the ULPI register port between two requesters with a timeout
module ulpi_reg_arbiter
  import ulpi_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          WE,
  input  logic [N_REQ*ADDR_W-1:0]   ADDR,
  input  logic [N_REQ*DATA_W-1:0]   WDATA,
  output logic [N_REQ-1:0]          ACK,
  output logic [N_REQ-1:0]          ERR,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      BUSY,
  output logic [ADDR_W-1:0]         REG_ADDR,
  output logic [DATA_W-1:0]         REG_DATA_WRITE,
  output logic                      REG_WRITE_REQ,
  output logic                      REG_READ_REQ,
  input  logic                      REG_WRITE_ACK,
  input  logic                      REG_READ_ACK,
  input  logic [DATA_W-1:0]         REG_DATA_READ
);
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic idx_q, idx_d, we_q, we_d, wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [N_REQ-1:0] ack_q, ack_d, err_q, err_d;
  logic gnt, hit, tout;
  ulpi_arb_rr u_rr (.req(REQ), .last(last_q), .gnt(gnt));
  assign hit = we_q ? REG_WRITE_ACK : REG_READ_ACK;
  assign tout = cnt_q == 16'(TIMEOUT - 1);
  // next state: grant and latch in IDLE, wait for ack or timeout in ISSUE, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    idx_d = idx_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    ack_d = '0;
    err_d = '0;
    rdata_d = '0;
    case (state_q)
      S_IDLE: if (|REQ) begin
        state_d = S_ISSUE;
        cnt_d = '0;
        idx_d = gnt;
        last_d = {1'b0, gnt};
        we_d = WE[gnt];
        addr_d = gnt ? ADDR[2*ADDR_W-1:ADDR_W] : ADDR[ADDR_W-1:0];
        wdata_d = gnt ? WDATA[2*DATA_W-1:DATA_W] : WDATA[DATA_W-1:0];
        wr_req_d = WE[gnt];
        rd_req_d = !WE[gnt];
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        if (hit || tout) begin
          state_d = S_DONE;
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          ack_d[idx_q] = hit;
          err_d[idx_q] = !hit;
          rdata_d = (hit && !we_q) ? REG_DATA_READ : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      last_q <= 2'd1;
      idx_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      ack_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      idx_q <= idx_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign ACK = ack_q;
  assign ERR = err_q;
  assign RDATA = rdata_q;
  assign BUSY = state_q != S_IDLE;
  assign REG_ADDR = addr_q;
  assign REG_DATA_WRITE = wdata_q;
  assign REG_WRITE_REQ = wr_req_q;
  assign REG_READ_REQ = rd_req_q;
endmodule

// File: doc/ulpi_reg_arbiter.md
ULPI_REG_ARBITER -- requirements
Module: ulpi_reg_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles a ULPI register access may stay outstanding before it is aborted; legal range 2..65535.
REQ-002 CLK  input  1  Single clock for all logic; same domain as the ULPI register port DATA_CLK side.
REQ-003 RST  input  1  Reset; synchronous, active-high.
REQ-004 REQ  input  2  Per-requester transaction request, level; bit i belongs to requester i (0 = init sequencer, 1 = host command path).
REQ-005 WE  input  2  Per-requester direction: 1 = register write, 0 = register read.
REQ-006 ADDR  input  12  Packed register addresses; requester i at [6i+5:6i].
REQ-007 WDATA  input  16  Packed write data; requester i at [8i+7:8i].
REQ-008 ACK  output  2  One-cycle completion pulse to requester i.
REQ-009 ERR  output  2  One-cycle timeout-abort pulse to requester i.
REQ-010 RDATA  output  8  Read result; valid only in the cycle ACK or ERR pulses.
REQ-011 BUSY  output  1  High while a transaction is granted (any state except IDLE).
REQ-012 REG_ADDR  output  6  Address to the ULPI register port.
REQ-013 REG_DATA_WRITE  output  8  Write data to the ULPI register port.
REQ-014 REG_WRITE_REQ  output  1  Level write request; held until REG_WRITE_ACK or timeout.
REQ-015 REG_READ_REQ  output  1  Level read request; held until REG_READ_ACK or timeout.
REQ-016 REG_WRITE_ACK / REG_READ_ACK  input  1 each  One-cycle completion pulses from the ULPI register port.
REQ-017 REG_DATA_READ  input  8  Read data; valid with REG_READ_ACK.

Function
REQ-018 FSM states: IDLE, ISSUE, DONE; all outputs registered.
REQ-019 IDLE: if any REQ bit high at edge k, latch winner's WE/ADDR/WDATA, enter ISSUE; REG_WRITE_REQ or REG_READ_REQ high from cycle k+1.
REQ-020 Arbitration: round-robin on 2-bit pointer LAST; single requester wins outright; when both request, winner is the index != LAST; LAST updates to the winner on grant.
REQ-021 Request inputs of a granted requester are sampled once at grant; later changes are ignored until completion.
REQ-022 ISSUE: 16-bit counter increments each cycle; counter clears on entry.
REQ-023 ISSUE + matching ack (REG_WRITE_ACK for write, REG_READ_ACK for read) at edge m: drop REG_*_REQ, pulse ACK[i] in cycle m+1, RDATA = REG_DATA_READ for reads and 0 for writes; enter DONE.
REQ-024 Non-matching ack in ISSUE is ignored.
REQ-025 Counter reaching TIMEOUT-1 without a matching ack: drop REG_*_REQ, pulse ERR[i], RDATA = 0, enter DONE.
REQ-026 Matching ack and timeout in the same cycle: ack wins; no ERR.
REQ-027 DONE lasts exactly one cycle, then IDLE; a REQ still high is re-arbitrated as a new transaction, so requesters drop REQ on ACK/ERR.
REQ-028 Any ack arriving in IDLE or DONE is ignored.
REQ-029 ACK and ERR are never both high, and at most one bit of ACK|ERR is high per cycle.
REQ-030 At most one of REG_WRITE_REQ/REG_READ_REQ is high in any cycle.

Reset
REQ-031 RST high at any edge: state IDLE, LAST = 1 (requester 0 wins first), counter 0, ACK/ERR/RDATA/BUSY/REG_* outputs 0; an in-flight transaction is abandoned without ACK or ERR.

Structure
REQ-032 Shared package ulpi_arb_pkg holds the state enum, N_REQ = 2, ADDR_W = 6, DATA_W = 8.
REQ-033 Round-robin grant choice lives in sub-module ulpi_arb_rr (combinational pick from REQ and LAST); the FSM, counter and data latching stay in ulpi_reg_arbiter.

Verification
REQ-034 Requester 0 writes 0x0A <- 0x55; port acks 3 cycles later -> REG_WRITE_REQ high 3 cycles, REG_ADDR = 0x0A, REG_DATA_WRITE = 0x55, ACK = 01, RDATA = 0.
REQ-035 Both requesters request simultaneously after reset, each held until ack -> grant order 0, 1, 0, 1 across 4 transactions.
REQ-036 Requester 1 reads 0x16; port returns 0xA5 -> ACK = 10 and RDATA = 0xA5 in the same cycle.
REQ-037 TIMEOUT = 8, port never acks -> REG_READ_REQ drops after 8 ISSUE cycles, ERR pulses, no ACK; REG_READ_ACK arriving 2 cycles later is ignored.
REQ-038 RST asserted mid-ISSUE, then port ack arrives -> all outputs 0 next cycle, no ACK/ERR, BUSY low, next grant goes to requester 0.
